// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state, address-field slicing and PLRU helpers for icache_assoc.
package icache_pkg;
  typedef enum logic {IDLE, REFILL} fsmState;
  function automatic logic [31:0] addrTag(input logic [31:0] addr, input int blockWidth, input int indexWidth);
    return addr >> (blockWidth + indexWidth);
  endfunction
  function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int blockWidth, input int indexWidth);
    return (addr >> blockWidth) & ((32'd1 << indexWidth) - 32'd1);
  endfunction
  function automatic logic [31:0] addrWord(input logic [31:0] addr, input int blockWidth);
    return (addr >> 2) & ((32'd1 << (blockWidth - 2)) - 32'd1);
  endfunction
  // Tree bits: [0] root (1 = right pair is LRU), [1] left pair, [2] right pair; each names the LRU side.
  function automatic logic [2:0] plruTouch(input logic [2:0] lru, input logic [1:0] way, input int ways);
    return ways == 4 ? {way[1] ? ~way[0] : lru[2], way[1] ? lru[1] : ~way[0], ~way[1]}
         : ways == 2 ? {2'b00, ~way[0]} : 3'b000;
  endfunction
  function automatic logic [1:0] plruVictim(input logic [2:0] lru, input int ways);
    return ways == 4 ? (lru[0] ? {1'b1, lru[2]} : {1'b0, lru[1]})
         : ways == 2 ? {1'b0, lru[0]} : 2'b00;
  endfunction
endpackage

// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and memory-refill signals of the instruction cache.
interface icache_assoc_if #(parameter int BLOCK_WIDTH = 4);
  logic instrReqIn;
  logic [31:0] instrAddrIn;
  logic flushIn;
  logic instrOutValid;
  logic [31:0] instrOut;
  logic miss;
  logic memReqOut;
  logic [31-BLOCK_WIDTH:0] memAddrOut;
  logic memDataValid;
  logic [(2**BLOCK_WIDTH)*8-1:0] memDataIn;
  modport master (
    output instrReqIn, instrAddrIn, flushIn, memDataValid, memDataIn,
    input instrOutValid, instrOut, miss, memReqOut, memAddrOut
  );
  modport slave (
    input instrReqIn, instrAddrIn, flushIn, memDataValid, memDataIn,
    output instrOutValid, instrOut, miss, memReqOut, memAddrOut
  );
endinterface

// File: rtl/icache_way.sv
// icache_way: one cache way -- valid bits, tag and data arrays, lookup compare and word select.
module icache_way #(
  parameter int BLOCK_WIDTH = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH = 22,
  parameter int WSEL_W = 2
) (
  input logic clkIn,
  input logic resetIn,
  input logic flushIn,
  input logic [INDEX_WIDTH-1:0] lookupIndex,
  input logic [TAG_WIDTH-1:0] lookupTag,
  input logic [WSEL_W-1:0] wordSel,
  output logic validOut,
  output logic match,
  output logic [31:0] wordOut,
  input logic wrEn,
  input logic [INDEX_WIDTH-1:0] wrIndex,
  input logic [TAG_WIDTH-1:0] wrTag,
  input logic [(2**BLOCK_WIDTH)*8-1:0] wrData
);
  localparam int SETS = 2**INDEX_WIDTH;
  localparam int WORDS = (2**BLOCK_WIDTH) / 4;
  logic [SETS-1:0] valid;
  logic [TAG_WIDTH-1:0] tagArr [SETS];
  logic [WORDS-1:0][31:0] dataArr [SETS];
  assign validOut = valid[lookupIndex];
  assign match = validOut && tagArr[lookupIndex] == lookupTag;
  assign wordOut = dataArr[lookupIndex][wordSel];
  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) valid <= '0;
    else if (flushIn) valid <= '0;
    else if (wrEn) valid[wrIndex] <= 1'b1;
  always_ff @(posedge clkIn)
    if (wrEn) begin
      tagArr[wrIndex] <= wrTag;
      dataArr[wrIndex] <= wrData;
    end
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative I-cache with PLRU replacement, single-refill FSM and flush.
// Define ICACHE_PERF_EN to add saturating hitCount/missCount outputs.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int WAY_WIDTH = 1,
  parameter int TAG_WIDTH = 32 - BLOCK_WIDTH - INDEX_WIDTH
) (
  input logic clkIn,
  input logic resetIn,
  icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
`endif
);
  localparam int SETS = 2**INDEX_WIDTH;
  localparam int WAYS = 2**WAY_WIDTH;
  localparam int WSEL_W = BLOCK_WIDTH > 2 ? BLOCK_WIDTH - 2 : 1;
  localparam int WI_W = WAY_WIDTH > 0 ? WAY_WIDTH : 1;
  fsmState state, stateNext;
  logic [31-BLOCK_WIDTH:0] memAddr;
  logic [WI_W-1:0] victim, victimNext, hitWay;
  logic drop, hit, wrEn, startRefill;
  logic [2:0] lru [SETS];
  logic [2:0] hitBase;
  logic [INDEX_WIDTH-1:0] idx, wrIdx;
  logic [TAG_WIDTH-1:0] tag, wrTag;
  logic [WSEL_W-1:0] wsel;
  logic [WAYS-1:0] validVec, matchVec;
  logic [31:0] words [WAYS];
  assign idx = INDEX_WIDTH'(addrIndex(bus.instrAddrIn, BLOCK_WIDTH, INDEX_WIDTH));
  assign tag = TAG_WIDTH'(addrTag(bus.instrAddrIn, BLOCK_WIDTH, INDEX_WIDTH));
  assign wsel = WSEL_W'(addrWord(bus.instrAddrIn, BLOCK_WIDTH));
  assign wrIdx = INDEX_WIDTH'(addrIndex({memAddr, {BLOCK_WIDTH{1'b0}}}, BLOCK_WIDTH, INDEX_WIDTH));
  assign wrTag = TAG_WIDTH'(addrTag({memAddr, {BLOCK_WIDTH{1'b0}}}, BLOCK_WIDTH, INDEX_WIDTH));
  for (genvar w = 0; w < WAYS; w++) begin : gWay
    icache_way #(
      .BLOCK_WIDTH(BLOCK_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH), .WSEL_W(WSEL_W)
    ) uWay (
      .clkIn(clkIn), .resetIn(resetIn), .flushIn(bus.flushIn),
      .lookupIndex(idx), .lookupTag(tag), .wordSel(wsel),
      .validOut(validVec[w]), .match(matchVec[w]), .wordOut(words[w]),
      .wrEn(wrEn && victim == WI_W'(w)), .wrIndex(wrIdx), .wrTag(wrTag), .wrData(bus.memDataIn)
    );
  end
  always_comb begin
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) if (matchVec[w]) hitWay = WI_W'(w);
    victimNext = WI_W'(plruVictim(lru[idx], WAYS));
    for (int w = WAYS - 1; w >= 0; w--) if (!validVec[w]) victimNext = WI_W'(w);
  end
  assign hit = bus.instrReqIn && |matchVec && !bus.flushIn;
  assign bus.instrOutValid = hit;
  assign bus.instrOut = hit ? words[hitWay] : 32'd0;
  assign bus.miss = bus.instrReqIn && !hit;
  assign bus.memReqOut = state == REFILL;
  assign bus.memAddrOut = memAddr;
  always_comb begin
    startRefill = state == IDLE && bus.instrReqIn && !hit && !bus.flushIn;
    wrEn = state == REFILL && bus.memDataValid && !drop && !bus.flushIn;
    stateNext = startRefill ? REFILL : (state == REFILL && bus.memDataValid) ? IDLE : state;
  end
  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) begin
      state <= IDLE;
      memAddr <= '0;
      victim <= '0;
      drop <= 1'b0;
    end else begin
      state <= stateNext;
      drop <= state == REFILL && !bus.memDataValid && (drop || bus.flushIn);
      if (startRefill) begin
        memAddr <= bus.instrAddrIn[31:BLOCK_WIDTH];
        victim <= victimNext;
      end
    end
  // A hit in the set being refilled must build on the refill's LRU update.
  assign hitBase = (wrEn && wrIdx == idx) ? plruTouch(lru[idx], 2'(victim), WAYS) : lru[idx];
  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) for (int s = 0; s < SETS; s++) lru[s] <= '0;
    else if (bus.flushIn) for (int s = 0; s < SETS; s++) lru[s] <= '0;
    else begin
      if (wrEn) lru[wrIdx] <= plruTouch(lru[wrIdx], 2'(victim), WAYS);
      if (hit) lru[idx] <= plruTouch(hitBase, 2'(hitWay), WAYS);
    end
`ifdef ICACHE_PERF_EN
  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) begin
      hitCount <= '0;
      missCount <= '0;
    end else begin
      if (hit && hitCount != '1) hitCount <= hitCount + 32'd1;
      if (startRefill && missCount != '1) missCount <= missCount + 32'd1;
    end
`endif
endmodule
